// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Width codes, MEM-stage FSM encoding and lane helper functions.
// Revision: 1.0
// ============================================================================
package mem_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_DONE = 2'd2
    } mem_state_e;

    function automatic logic [3:0] be_gen(input logic [1:0] width, input logic [1:0] off);
        case (width)
            WIDTH_BYTE: be_gen = 4'b0001 << off;
            WIDTH_HALF: be_gen = 4'b0011 << {off[1], 1'b0};
            default:    be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_replicate(input logic [1:0] width, input logic [31:0] d);
        case (width)
            WIDTH_BYTE: store_replicate = {4{d[7:0]}};
            WIDTH_HALF: store_replicate = {2{d[15:0]}};
            WIDTH_WORD: store_replicate = d;
            default:    store_replicate = d;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [1:0] width, input logic sign,
                                                 input logic [1:0] off, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (width)
            WIDTH_BYTE: load_extract = {{24{sign & b[7]}}, b};
            WIDTH_HALF: load_extract = {{16{sign & h[15]}}, h};
            default:    load_extract = word;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_load_align
// Brief   : Load lane select and sign/zero extension (shared with WB forwarding).
// Revision: 1.0
// ============================================================================
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  width,
    input  logic        sign,
    input  logic [1:0]  offset,
    output logic [31:0] data
);

    assign data = load_extract(width, sign, offset, rdata);

endmodule
`default_nettype wire

// File: rtl/mem_stage_access.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_access
// Brief   : MEM-stage single-outstanding req/ack bus access with lane handling.
// Revision: 1.0
// ============================================================================
module mem_stage_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        flush,
    input  logic        MEM_MemRead,
    input  logic        MEM_MemWrite,
    input  logic        MEM_IORead,
    input  logic        MEM_IOWrite,
    input  logic        MEM_Memory_sign,
    input  logic [1:0]  MEM_Memory_data_width,
    input  logic [31:0] MEM_ALU_Result,
    input  logic [31:0] MEM_Data_In,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_io,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    output logic        mem_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        adel,
    output logic        ades,
    output logic [31:0] bad_vaddr,
    output logic        bus_err
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT - 1);

    mem_state_e       r_state;
    logic             r_we, r_io, r_sign, r_abort, r_ld_ok;
    logic             r_adel, r_ades, r_err;
    logic [1:0]       r_width, r_off;
    logic [3:0]       r_be;
    logic [31:0]      r_addr, r_wdata, r_load_data, r_bad_vaddr;
    logic [CNT_W-1:0] r_cnt;

    logic             w_access, w_is_wr, w_is_io, w_misaligned, w_issue;
    logic [31:0]      w_load_ext;

    assign w_access = MEM_MemRead | MEM_MemWrite | MEM_IORead | MEM_IOWrite;
    assign w_is_wr  = MEM_MemWrite | MEM_IOWrite;
    assign w_is_io  = MEM_IORead | MEM_IOWrite;

    always_comb begin
        w_misaligned = 1'b0;
        case (MEM_Memory_data_width)
            WIDTH_BYTE: w_misaligned = 1'b0;
            WIDTH_HALF: w_misaligned = MEM_ALU_Result[0];
            default:    w_misaligned = |MEM_ALU_Result[1:0];
        endcase
    end

    assign w_issue = (r_state == S_IDLE) && w_access && !w_misaligned && !flush;

    mem_load_align u_load_align (
        .rdata  (bus_rdata),
        .width  (r_width),
        .sign   (r_sign),
        .offset (r_off),
        .data   (w_load_ext)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_io        <= 1'b0;
            r_sign      <= 1'b0;
            r_abort     <= 1'b0;
            r_ld_ok     <= 1'b0;
            r_adel      <= 1'b0;
            r_ades      <= 1'b0;
            r_err       <= 1'b0;
            r_width     <= 2'b00;
            r_off       <= 2'b00;
            r_be        <= 4'b0000;
            r_addr      <= 32'h0;
            r_wdata     <= 32'h0;
            r_load_data <= 32'h0;
            r_bad_vaddr <= 32'h0;
            r_cnt       <= '0;
        end else begin
            r_adel <= 1'b0;
            r_ades <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt   <= '0;
                    r_abort <= 1'b0;
                    r_ld_ok <= 1'b0;
                    // A flushed instruction neither issues nor raises an alignment fault.
                    if (w_access && !flush) begin
                        if (w_misaligned) begin
                            r_ades      <= w_is_wr;
                            r_adel      <= !w_is_wr;
                            r_bad_vaddr <= MEM_ALU_Result;
                        end else begin
                            r_we    <= w_is_wr;
                            r_io    <= w_is_io;
                            r_addr  <= {MEM_ALU_Result[31:2], 2'b00};
                            r_be    <= be_gen(MEM_Memory_data_width, MEM_ALU_Result[1:0]);
                            r_wdata <= store_replicate(MEM_Memory_data_width, MEM_Data_In);
                            r_width <= MEM_Memory_data_width;
                            r_sign  <= MEM_Memory_sign;
                            r_off   <= MEM_ALU_Result[1:0];
                            r_state <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (flush) r_abort <= 1'b1;
                    if (bus_ack) begin
                        if (!r_we) r_load_data <= w_load_ext;
                        r_ld_ok <= !r_we && !r_abort && !flush;
                        r_state <= S_DONE;
                    end else if (r_cnt == c_cnt_last) begin
                        r_err   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus_req    = (r_state == S_BUS);
    assign bus_we     = r_we;
    assign bus_io     = r_io;
    assign bus_addr   = r_addr;
    assign bus_be     = r_be;
    assign bus_wdata  = r_wdata;
    assign mem_stall  = !reset && (w_issue || (r_state == S_BUS));
    assign load_data  = r_load_data;
    assign load_valid = (r_state == S_DONE) && r_ld_ok && !flush;
    assign adel       = r_adel;
    assign ades       = r_ades;
    assign bad_vaddr  = r_bad_vaddr;
    assign bus_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_access.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_access
// Brief   : Scoreboard bench for mem_stage_access (TIMEOUT = 4).
// Revision: 1.0
// ============================================================================
module tb_mem_stage_access;

    localparam int TO = 4;

    logic        clock = 1'b0;
    logic        reset, flush;
    logic        MEM_MemRead, MEM_MemWrite, MEM_IORead, MEM_IOWrite, MEM_Memory_sign;
    logic [1:0]  MEM_Memory_data_width;
    logic [31:0] MEM_ALU_Result, MEM_Data_In;
    logic        bus_req, bus_we, bus_io, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
    logic        mem_stall, load_valid, adel, ades, bus_err;
    logic [31:0] load_data, bad_vaddr;

    mem_stage_access #(.TIMEOUT(TO), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .MEM_IORead(MEM_IORead), .MEM_IOWrite(MEM_IOWrite),
        .MEM_Memory_sign(MEM_Memory_sign), .MEM_Memory_data_width(MEM_Memory_data_width),
        .MEM_ALU_Result(MEM_ALU_Result), .MEM_Data_In(MEM_Data_In),
        .bus_req(bus_req), .bus_we(bus_we), .bus_io(bus_io), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .mem_stall(mem_stall), .load_data(load_data), .load_valid(load_valid),
        .adel(adel), .ades(ades), .bad_vaddr(bad_vaddr), .bus_err(bus_err)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic        io;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } req_t;

    req_t        req_q[$];
    logic [31:0] ld_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic        prev_req = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        else
            n_pass++;
    endtask

    // Scoreboard: bus requests checked on their first cycle, loads on load_valid.
    always @(negedge clock) begin
        req_t e;
        if (bus_req && !prev_req) begin
            if (req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
            else begin
                e = req_q.pop_front();
                chk("req_we",    {31'd0, bus_we}, {31'd0, e.we});
                chk("req_io",    {31'd0, bus_io}, {31'd0, e.io});
                chk("req_addr",  bus_addr, e.addr);
                chk("req_be",    {28'd0, bus_be}, {28'd0, e.be});
                chk("req_wdata", bus_wdata, e.wdata);
            end
        end
        if (load_valid) begin
            if (ld_q.size() == 0) chk("unexpected_load", 32'd1, 32'd0);
            else chk("load_data", load_data, ld_q.pop_front());
        end
        prev_req = bus_req;
    end

    task automatic clear_inputs();
        {MEM_MemRead, MEM_MemWrite, MEM_IORead, MEM_IOWrite} = 4'b0000;
        MEM_Memory_sign = 1'b0;
        MEM_Memory_data_width = 2'b00;
        MEM_ALU_Result = 32'h0;
        MEM_Data_In = 32'h0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"},   {31'd0, bus_req}, 32'd0);
        chk({tag, "_we"},    {31'd0, bus_we}, 32'd0);
        chk({tag, "_io"},    {31'd0, bus_io}, 32'd0);
        chk({tag, "_addr"},  bus_addr, 32'd0);
        chk({tag, "_be"},    {28'd0, bus_be}, 32'd0);
        chk({tag, "_wdata"}, bus_wdata, 32'd0);
        chk({tag, "_ld"},    load_data, 32'd0);
        chk({tag, "_lv"},    {31'd0, load_valid}, 32'd0);
        chk({tag, "_adel"},  {31'd0, adel}, 32'd0);
        chk({tag, "_ades"},  {31'd0, ades}, 32'd0);
        chk({tag, "_bva"},   bad_vaddr, 32'd0);
        chk({tag, "_err"},   {31'd0, bus_err}, 32'd0);
        chk({tag, "_stall"}, {31'd0, mem_stall}, 32'd0);
    endtask

    // Called at a negedge. ctl = {MemRead, MemWrite, IORead, IOWrite}; ack_at/flush_at
    // count BUS cycles from 1 (0 = never). Inputs are withdrawn after the first edge
    // at which mem_stall is low, as the EX/MEM register would advance there.
    task automatic access(input string tag, input logic [3:0] ctl, input logic sgn,
                          input logic [1:0] wid, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] rdata, input int ack_at, input int flush_at,
                          input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld,
                          input int ereq, input int estall, input int elv,
                          input int eadel, input int eades, input int eerr);
        int  nreq = 0, nstall = 0, nlv = 0, nadel = 0, nades = 0, nerr = 0;
        bit  rel;
        if (ereq > 0)
            req_q.push_back('{we: ctl[2] | ctl[0], io: ctl[1] | ctl[0],
                              addr: {addr[31:2], 2'b00}, be: ebe, wdata: ewd});
        if (elv > 0) ld_q.push_back(eld);
        {MEM_MemRead, MEM_MemWrite, MEM_IORead, MEM_IOWrite} = ctl;
        MEM_Memory_sign = sgn;
        MEM_Memory_data_width = wid;
        MEM_ALU_Result = addr;
        MEM_Data_In = data;
        bus_rdata = rdata;
        for (int c = 0; c < 12; c++) begin
            #1;
            nstall += int'(mem_stall);
            if (bus_req) nreq++;
            nlv   += int'(load_valid);
            nadel += int'(adel);
            nades += int'(ades);
            nerr  += int'(bus_err);
            rel = !mem_stall;
            bus_ack = bus_req && (nreq == ack_at);
            flush   = bus_req && (nreq == flush_at);
            @(posedge clock);
            #1;
            bus_ack = 1'b0;
            flush = 1'b0;
            if (rel) clear_inputs();
            @(negedge clock);
        end
        chk({tag, "_req_cycles"},   nreq, ereq);
        chk({tag, "_stall_cycles"}, nstall, estall);
        chk({tag, "_load_valid"},   nlv, elv);
        chk({tag, "_adel"},         nadel, eadel);
        chk({tag, "_ades"},         nades, eades);
        chk({tag, "_bus_err"},      nerr, eerr);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        bus_ack = 1'b0;
        bus_rdata = 32'h0;
        clear_inputs();
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        //     tag     ctl     sg wid    addr          data          rdata      ack fl  be       wdata         load         rq st lv ad as er
        access("lb",   4'b1000, 1, 2'b00, 32'h0000_1003, 32'h0,        32'h80FF_FF7F, 2, 0, 4'b1000, 32'h0,        32'hFFFF_FF80, 2, 3, 1, 0, 0, 0);
        access("sh",   4'b0100, 0, 2'b01, 32'h0000_2002, 32'h1234_ABCD, 32'h0,        1, 0, 4'b1100, 32'hABCD_ABCD, 32'h0,        1, 2, 0, 0, 0, 0);
        access("lw_mis", 4'b1000, 0, 2'b10, 32'h0000_0006, 32'h0,      32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 1, 0, 0);
        chk("bad_vaddr_lw", bad_vaddr, 32'h0000_0006);
        access("io_to", 4'b0010, 0, 2'b10, 32'h0000_0040, 32'h0,       32'h0,        0, 0, 4'b1111, 32'h0,        32'h0,        TO, TO + 1, 0, 0, 0, 1);
        chk("io_to_idle", {31'd0, bus_req}, 32'd0);
        access("lbu_fl", 4'b1000, 0, 2'b00, 32'h0000_0001, 32'h0,      32'h1111_2222, 3, 2, 4'b0010, 32'h0,        32'h0,        3, 4, 0, 0, 0, 0);
        access("lbu",  4'b1000, 0, 2'b00, 32'h0000_0001, 32'h0,        32'h0000_9A00, 1, 0, 4'b0010, 32'h0,        32'h0000_009A, 1, 2, 1, 0, 0, 0);
        access("lh",   4'b1000, 1, 2'b01, 32'h0000_0102, 32'h0,        32'h8001_1234, 1, 0, 4'b1100, 32'h0,        32'hFFFF_8001, 1, 2, 1, 0, 0, 0);
        access("sb",   4'b0100, 0, 2'b00, 32'h0000_0105, 32'h0000_00A5, 32'h0,       3, 0, 4'b0010, 32'hA5A5_A5A5, 32'h0,        3, 4, 0, 0, 0, 0);
        access("iow",  4'b0001, 0, 2'b10, 32'h0000_0200, 32'hCAFE_F00D, 32'h0,       1, 0, 4'b1111, 32'hCAFE_F00D, 32'h0,        1, 2, 0, 0, 0, 0);
        access("rw",   4'b1100, 0, 2'b11, 32'h0000_000C, 32'h5555_AAAA, 32'h1234_5678, 1, 0, 4'b1111, 32'h5555_AAAA, 32'h0,      1, 2, 0, 0, 0, 0);
        access("sh_mis", 4'b0100, 0, 2'b01, 32'h0000_0005, 32'h0,      32'h0,        1, 0, 4'b0000, 32'h0,        32'h0,        0, 0, 0, 0, 1, 0);
        chk("bad_vaddr_sh", bad_vaddr, 32'h0000_0005);
        chk("load_data_held", load_data, 32'hFFFF_8001);

        // Reset while a store is waiting in BUS.
        req_q.push_back('{we: 1'b1, io: 1'b0, addr: 32'h20, be: 4'b1111, wdata: 32'h0BAD_F00D});
        MEM_MemWrite = 1'b1;
        MEM_Memory_data_width = 2'b10;
        MEM_ALU_Result = 32'h20;
        MEM_Data_In = 32'h0BAD_F00D;
        @(posedge clock); #1;
        @(posedge clock); #1;
        chk("pre_reset_req", {31'd0, bus_req}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        check_all_zero("mid_reset");
        clear_inputs();
        @(negedge clock);
        reset = 1'b0;
        access("sw",   4'b0100, 0, 2'b10, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,       1, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0,        1, 2, 0, 0, 0, 0);

        chk("req_q_empty", req_q.size(), 32'd0);
        chk("ld_q_empty",  ld_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
